logic16_arbiter: RTL and testbench

LOGIC16_ARBITER -- requirements
Module: logic16_arbiter

---
 rtl/logic16_arbiter.sv | 244 ++++++++++++++++++++++++
 tb/tb_logic16_arbiter.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic16_arbiter.sv
// -----------------------------------------------------------------------------
// logic16_arbiter
//
// Round-robin arbiter in front of a single bitwise logic unit. Up to N_REQ
// requesters each present an opcode and two WIDTH-bit operands. One requester
// is granted at a time. Its operands are captured and evaluated, and the result
// is held on the response port until the consumer takes it.
//
// Opcodes: 00 AND, 01 OR, 10 NOT A (b ignored), 11 XOR.
//
// Build option:
//   LOGIC16_ARB_XOR_EN  defined   : op 11 returns a ^ b with rsp_err = 0.
//                       undefined : op 11 returns 0 with rsp_err = 1, and no
//                                   XOR datapath is built. Handshake timing is
//                                   identical in both builds.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   [N_REQ]        per-requester request
//   req_ready  out  [N_REQ]        per-requester grant (one-hot or zero, IDLE only)
//   req_op     in   [2*N_REQ]      opcode, slice i = [2i+1:2i]
//   req_a      in   [WIDTH*N_REQ]  operand a, slice i = [WIDTH*i +: WIDTH]
//   req_b      in   [WIDTH*N_REQ]  operand b, slice i = [WIDTH*i +: WIDTH]
//   rsp_valid  out  result available (HOLD)
//   rsp_ready  in   consumer accepts result
//   rsp_id     out  [clog2(N_REQ)] requester that owns the result
//   rsp_data   out  [WIDTH]        result value
//   rsp_err    out  illegal-opcode flag
//   busy       out  a result is being held for the consumer
//
// Timing: an accept at edge T gives EXEC for one cycle and HOLD from edge T+1.
// The response handshake can complete at edge T+2, and the next accept can
// happen at edge T+3.
// -----------------------------------------------------------------------------
module logic16_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [2*N_REQ-1:0]       req_op,
  input  logic [WIDTH*N_REQ-1:0]   req_a,
  input  logic [WIDTH*N_REQ-1:0]   req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(N_REQ)-1:0] rsp_id,
  output logic [WIDTH-1:0]         rsp_data,
  output logic                     rsp_err,
  output logic                     busy
);

  localparam int IDW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_NOTA = 2'b10,
    OP_XOR  = 2'b11
  } op_t;

  // State and captured request.
  state_t             state_q;
  logic [IDW-1:0]     ptr_q;
  op_t                op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [IDW-1:0]     id_q;

  // Registered response outputs.
  logic               rsp_valid_q;
  logic               busy_q;
  logic [WIDTH-1:0]   rsp_data_q;
  logic [IDW-1:0]     rsp_id_q;
  logic               rsp_err_q;

  // Arbitration and datapath signals.
  logic               grant_found;
  logic [IDW-1:0]     grant_idx;
  logic [IDW-1:0]     cand;
  logic [IDW-1:0]     ptr_d;
  logic [1:0]         sel_op;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;
  logic [WIDTH-1:0]   result_d;
  logic               err_d;

  // ---------------------------------------------------------------------------
  // Round-robin search. Scanning starts at ptr_q and wraps modulo N_REQ. The
  // first asserted request wins. A grant is offered only in IDLE, so the grant
  // depends only on req_valid and registered state.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first; otherwise a path
    // that skips an assignment would infer a latch.
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = IDW'((int'(ptr_q) + k) % N_REQ);
      if ((state_q == IDLE) && !grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign req_ready = grant_found ? (N_REQ'(1) << grant_idx) : '0;

  // The pointer moves past the winner only when an accept happens.
  assign ptr_d = (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + IDW'(1);

  // Select the winner's opcode and operands. Comparing against constant
  // indices keeps every part-select static.
  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        sel_op = req_op[2*i +: 2];
        sel_a  = req_a[WIDTH*i +: WIDTH];
        sel_b  = req_b[WIDTH*i +: WIDTH];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Logic unit, evaluated on the captured operands during EXEC.
  // ---------------------------------------------------------------------------
  always_comb begin
    result_d = '0;
    err_d    = 1'b0;
    case (op_q)
      OP_AND:  result_d = a_q & b_q;
      OP_OR:   result_d = a_q | b_q;
      OP_NOTA: result_d = ~a_q;
      OP_XOR: begin
`ifdef LOGIC16_ARB_XOR_EN
        result_d = a_q ^ b_q;
`else
        // Without the XOR datapath, op 11 is reported as illegal and
        // result_d stays at its zero default.
        err_d = 1'b1;
`endif
      end
      default: begin
        result_d = '0;
        err_d    = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs.
  //   IDLE -> EXEC on accept: capture op/a/b/id and advance the pointer.
  //   EXEC -> HOLD always: register the result and raise rsp_valid/busy.
  //   HOLD -> IDLE on rsp_ready: drop rsp_valid/busy. No grant is possible
  //           in this cycle because req_ready is only non-zero in IDLE.
  // busy rises together with rsp_valid, so it is low in EXEC and high while a
  // result is being held.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the operand registers are reset too. They are a handful of
      // flops, not a memory, and a reset value keeps them out of X on idle
      // paths.
      state_q     <= IDLE;
      ptr_q       <= '0;
      op_q        <= OP_AND;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register samples
      // pre-edge values regardless of statement order.
      case (state_q)
        IDLE: begin
          if (grant_found) begin
            op_q    <= op_t'(sel_op);
            a_q     <= sel_a;
            b_q     <= sel_b;
            id_q    <= grant_idx;
            ptr_q   <= ptr_d;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          rsp_data_q  <= result_d;
          rsp_err_q   <= err_d;
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
          busy_q      <= 1'b1;
          state_q     <= HOLD;
        end
        HOLD: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign busy      = busy_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_err   = rsp_err_q;

  // ---------------------------------------------------------------------------
  // Interface properties.
  // ---------------------------------------------------------------------------
  a_ready_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(req_ready));

  a_ready_idle_only : assert property (@(posedge clk) disable iff (!rst_n)
    (state_q != IDLE) |-> (req_ready == '0));

  a_rsp_hold_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (rsp_valid && !rsp_ready) |=>
      (rsp_valid && $stable(rsp_data) && $stable(rsp_id) && $stable(rsp_err)));

endmodule

// File: tb/tb_logic16_arbiter.sv
// -----------------------------------------------------------------------------
// tb_logic16_arbiter
//
// Self-checking bench for logic16_arbiter (N_REQ=4, WIDTH=16). Inputs are
// driven at the falling edge, and outputs are sampled 1 ns later, well away
// from the rising edge. A transaction-level reference model runs beside the
// DUT. It tracks the round-robin pointer, whether a result is outstanding,
// how many edges have passed since the accept, and the expected result
// computed when the accept happens.
// -----------------------------------------------------------------------------
module tb_logic16_arbiter;

  localparam int N = 4;
  localparam int W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req_valid = '0;
  logic [N-1:0]     req_ready;
  logic [2*N-1:0]   req_op = '0;
  logic [W*N-1:0]   req_a = '0;
  logic [W*N-1:0]   req_b = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [1:0]       rsp_id;
  logic [W-1:0]     rsp_data;
  logic             rsp_err;
  logic             busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  logic16_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int           m_ptr  = 0;
  bit           m_free = 1'b1;   // no request outstanding
  int           m_age  = 0;      // edges since accept (0: computing, 1: result shown)
  int           m_id   = 0;
  logic [W-1:0] m_data = '0;
  bit           m_err  = 1'b0;

  function automatic int winner(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic void golden(input logic [1:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, output logic [W-1:0] d,
                                 output bit e);
    e = 1'b0;
    case (op)
      2'b00:   d = a & b;
      2'b01:   d = a | b;
      2'b10:   d = ~a;
      default: begin
`ifdef LOGIC16_ARB_XOR_EN
        d = a ^ b;
`else
        d = '0;
        e = 1'b1;
`endif
      end
    endcase
  endfunction

  function automatic logic [N-1:0] model_ready();
    logic [N-1:0] r;
    int w;
    r = '0;
    w = winner(req_valid, m_ptr);
    if (m_free && w >= 0) r[w] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    m_ptr  = 0;
    m_free = 1'b1;
    m_age  = 0;
  endtask

  // Apply the coming rising edge to the model using the inputs that are
  // currently driven, then move on to the next falling edge.
  task automatic advance();
    int w;
    if (m_free) begin
      w = winner(req_valid, m_ptr);
      if (w >= 0) begin
        m_id = w;
        golden(req_op[2*w +: 2], req_a[W*w +: W], req_b[W*w +: W], m_data, m_err);
        m_ptr  = (w + 1) % N;
        m_free = 1'b0;
        m_age  = 0;
      end
    end else if (m_age == 0) begin
      m_age = 1;
    end else if (rsp_ready) begin
      m_free = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic drive(input int i, input logic [1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    req_op[2*i +: 2] = op;
    req_a[W*i +: W]  = a;
    req_b[W*i +: W]  = b;
  endtask

  // Hold reset across one rising edge, then release it between edges.
  task automatic pulse_reset();
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({rsp_valid, busy, rsp_err, req_ready, rsp_id, rsp_data} !== 25'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %h required 0",
               {rsp_valid, busy, rsp_err, req_ready, rsp_id, rsp_data});
    end
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_single();
    rsp_ready = 1'b1;
    drive(0, 2'b00, 16'hF0F0, 16'hFF00);
    req_valid = 4'b0001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL single_grant: got %b required 0001", req_ready);
    end
    advance();
    req_valid = '0;
    #1;
    checks++;
    if ({rsp_valid, busy, req_ready} !== 6'd0) begin
      failures++;
      $display("FAIL single_exec_quiet: got %b required 000000", {rsp_valid, busy, req_ready});
    end
    advance();
    #1;
    checks++;
    if ({rsp_valid, busy, rsp_id, rsp_data, rsp_err} !== {1'b1, 1'b1, 2'd0, 16'hF000, 1'b0}) begin
      failures++;
      $display("FAIL single_result: valid=%b busy=%b id=%0d data=%h err=%b required 1 1 0 f000 0",
               rsp_valid, busy, rsp_id, rsp_data, rsp_err);
    end
    advance();
    #1;
    checks++;
    if ({rsp_valid, busy} !== 2'b00) begin
      failures++;
      $display("FAIL single_release: got valid=%b busy=%b required 0 0", rsp_valid, busy);
    end
  endtask

  task automatic test_fairness();
    pulse_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) drive(i, 2'($urandom), 16'($urandom), 16'($urandom));
    req_valid = 4'b1111;
    for (int c = 0; c < 15; c++) begin
      logic [N-1:0] exp_r;
      logic [2:0]   exp_v;
      #1;
      exp_r = (c % 3 == 0) ? (N'(1) << ((c / 3) % N)) : '0;
      checks++;
      if (req_ready !== exp_r) begin
        failures++;
        $display("FAIL fair_grant cycle %0d: got %b required %b", c, req_ready, exp_r);
      end
      exp_v = (c % 3 == 2) ? {1'b1, 2'((c / 3) % N)} : 3'b000;
      checks++;
      if ({rsp_valid, (rsp_valid ? rsp_id : 2'd0)} !== exp_v) begin
        failures++;
        $display("FAIL fair_rsp cycle %0d: valid=%b id=%0d required %b", c, rsp_valid, rsp_id, exp_v);
      end
      advance();
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    drive(2, 2'b10, 16'h1234, 16'($urandom));
    rsp_ready = 1'b0;
    req_valid = 4'b0100;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      failures++;
      $display("FAIL bp_grant: got %b required 0100", req_ready);
    end
    advance();
    req_valid = '0;
    #1;
    checks++;
    if ({rsp_valid, busy, req_ready} !== 6'd0) begin
      failures++;
      $display("FAIL bp_exec_quiet: got %b required 000000", {rsp_valid, busy, req_ready});
    end
    advance();
    req_valid = 4'b1011;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if ({rsp_valid, busy, req_ready, rsp_data, rsp_id} !== {1'b1, 1'b1, 4'b0000, 16'hEDCB, 2'd2}) begin
        failures++;
        $display("FAIL bp_hold cycle %0d: valid=%b busy=%b ready=%b data=%h id=%0d required 1 1 0000 edcb 2",
                 c, rsp_valid, busy, req_ready, rsp_data, rsp_id);
      end
      advance();
    end
    rsp_ready = 1'b1;
    #1;
    checks++;
    if ({rsp_valid, req_ready, rsp_data} !== {1'b1, 4'b0000, 16'hEDCB}) begin
      failures++;
      $display("FAIL bp_release_cycle: valid=%b ready=%b data=%h required 1 0000 edcb",
               rsp_valid, req_ready, rsp_data);
    end
    advance();
    #1;
    checks++;
    if ({rsp_valid, busy, req_ready} !== {1'b0, 1'b0, 4'b1000}) begin
      failures++;
      $display("FAIL bp_idle: valid=%b busy=%b ready=%b required 0 0 1000", rsp_valid, busy, req_ready);
    end
    req_valid = '0;
    advance();
  endtask

  task automatic test_xor_op();
    logic [W-1:0] exp_d;
    logic         exp_e;
`ifdef LOGIC16_ARB_XOR_EN
    exp_d = 16'h5555;
    exp_e = 1'b0;
`else
    exp_d = 16'h0000;
    exp_e = 1'b1;
`endif
    drive(3, 2'b11, 16'hAAAA, 16'hFFFF);
    rsp_ready = 1'b1;
    req_valid = 4'b1000;
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin
      failures++;
      $display("FAIL xor_grant: got %b required 1000", req_ready);
    end
    advance();
    req_valid = '0;
    advance();
    #1;
    checks++;
    if ({rsp_valid, rsp_id, rsp_data, rsp_err} !== {1'b1, 2'd3, exp_d, exp_e}) begin
      failures++;
      $display("FAIL xor_result: valid=%b id=%0d data=%h err=%b required 1 3 %h %b",
               rsp_valid, rsp_id, rsp_data, rsp_err, exp_d, exp_e);
    end
    advance();
  endtask

  task automatic test_wrap();
    rsp_ready = 1'b1;
    drive(0, 2'($urandom), 16'($urandom), 16'($urandom));
    drive(2, 2'($urandom), 16'($urandom), 16'($urandom));
    req_valid = 4'b0100;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      failures++;
      $display("FAIL wrap_setup: got %b required 0100", req_ready);
    end
    advance();
    req_valid = '0;
    advance();
    advance();
    req_valid = 4'b0101;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL wrap_grant: got %b required 0001", req_ready);
    end
    advance();
    req_valid = '0;
    advance();
    advance();
    req_valid = 4'b0101;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      failures++;
      $display("FAIL wrap_ptr_next: got %b required 0100", req_ready);
    end
    req_valid = '0;
    advance();
  endtask

  task automatic test_reset_mid_op();
    // Reset while in EXEC.
    rsp_ready = 1'b1;
    drive(1, 2'b00, 16'hFFFF, 16'h0F0F);
    req_valid = 4'b0010;
    #1;
    advance();
    req_valid = '0;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({rsp_valid, busy, req_ready} !== 6'd0) begin
      failures++;
      $display("FAIL rst_exec_async: got %b required 000000", {rsp_valid, busy, req_ready});
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    drive(1, 2'b01, 16'h1234, 16'h0000);
    drive(3, 2'($urandom), 16'($urandom), 16'($urandom));
    req_valid = 4'b1010;
    #1;
    checks++;
    if ({rsp_valid, req_ready} !== {1'b0, 4'b0010}) begin
      failures++;
      $display("FAIL rst_first_grant: valid=%b ready=%b required 0 0010", rsp_valid, req_ready);
    end
    rsp_ready = 1'b0;
    advance();
    req_valid = '0;
    advance();
    #1;
    checks++;
    if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd1, 16'h1234}) begin
      failures++;
      $display("FAIL rst_after_release: valid=%b id=%0d data=%h required 1 1 1234",
               rsp_valid, rsp_id, rsp_data);
    end
    // Reset while in HOLD: outputs must clear immediately.
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({rsp_valid, busy, rsp_err, rsp_id, rsp_data} !== 21'd0) begin
      failures++;
      $display("FAIL rst_hold_async: got %h required 0", {rsp_valid, busy, rsp_err, rsp_id, rsp_data});
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    rsp_ready = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if ({rsp_valid, busy} !== 2'b00) begin
        failures++;
        $display("FAIL rst_discard cycle %0d: valid=%b busy=%b required 0 0", c, rsp_valid, busy);
      end
      advance();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      logic [N-1:0] exp_r;
      bit           exp_v;
      req_valid = N'($urandom);
      req_op    = 8'($urandom);
      req_a     = {$urandom, $urandom};
      req_b     = {$urandom, $urandom};
      rsp_ready = ($urandom % 4) != 0;
      #1;
      exp_r = model_ready();
      exp_v = !m_free && (m_age == 1);
      checks++;
      if (req_ready !== exp_r) begin
        failures++;
        $display("FAIL rand_ready cycle %0d: got %b required %b", c, req_ready, exp_r);
      end
      checks++;
      if ({rsp_valid, busy} !== {exp_v, exp_v}) begin
        failures++;
        $display("FAIL rand_valid_busy cycle %0d: got %b%b required %b%b", c, rsp_valid, busy, exp_v, exp_v);
      end
      if (exp_v) begin
        checks++;
        if ({rsp_id, rsp_data, rsp_err} !== {2'(m_id), m_data, m_err}) begin
          failures++;
          $display("FAIL rand_result cycle %0d: id=%0d data=%h err=%b required %0d %h %b",
                   c, rsp_id, rsp_data, rsp_err, m_id, m_data, m_err);
        end
      end
      advance();
    end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_xor_op();
    test_wrap();
    test_reset_mid_op();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
